fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose these ports (clock and reset first):
  clk  in  1  system clock; all state updates on rising edge
  reset  in  1  synchronous, active-low reset; 0 at a rising edge resets the block
  EN  in  1  advance from hazard unit; 1 = F/D register loads this cycle
  redirect  in  1  branch/jump taken, from decode stage
  redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 00
  imem_req  out  1  instruction-memory request
  imem_addr  out  32  word-aligned fetch address
  imem_ack  in  1  memory response valid; imem_rdata valid this cycle
  imem_rdata  in  32  instruction word
  InstrF  out  32  instruction to F/D register; 0 (nop) when ValidF=0
  PC_4F  out  32  fetch PC + 4
  ValidF  out  1  InstrF holds a live instruction
REQ-002 The block SHALL use one clock, clk; reset SHALL be synchronous and active-low, sampled only on rising clk.

Function
REQ-003 The block SHALL hold a 32-bit PC register, reset value 32'h0000_3000.
REQ-004 The state machine SHALL have the states IDLE, REQ, HOLD and KILL.
REQ-005 IDLE: imem_req=0, ValidF=0; next cycle -> REQ unconditionally; IDLE is reachable only through reset.
REQ-006 REQ: imem_req=1, imem_addr=PC. On imem_ack with redirect=0: capture imem_rdata into the instruction buffer, go to HOLD.
REQ-007 REQ with redirect=1 and imem_ack=1 in the same cycle: discard the data, PC<=redirect_pc, stay in REQ.
REQ-008 REQ with redirect=1 and imem_ack=0: PC<=redirect_pc, go to KILL. imem_addr SHALL keep the old address until ack, because the address must stay stable while imem_req=1.
REQ-009 KILL: imem_req=1 at the old address; on imem_ack discard the data, go to REQ at the new PC; a further redirect in KILL overwrites the pending PC.
REQ-010 HOLD: ValidF=1, InstrF=buffer, PC_4F=PC+4, imem_req=0.
REQ-011 HOLD with redirect=1: PC<=redirect_pc, ValidF=0 the next cycle, go to REQ. Redirect SHALL take priority over EN.
REQ-012 HOLD with EN=1 and redirect=0: PC<=PC+4, go to REQ.
REQ-013 HOLD with EN=0 and redirect=0: hold all outputs unchanged.
REQ-014 PC arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-015 Outside HOLD, ValidF=0, InstrF=0 and PC_4F=PC+4. A bypass cycle under REQ-019 is the only exception.

Reset
REQ-016 While reset=0 at a clock edge, the block SHALL load these values: state=IDLE, PC=32'h0000_3000, buffer=0.
REQ-017 The outputs during and immediately after reset SHALL be: ValidF=0, InstrF=0, PC_4F=32'h0000_3004, imem_req=0.
REQ-018 Reset in REQ or KILL SHALL abandon the outstanding request. An imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-019 With macro FETCH_BYPASS_EN defined, the REQ state SHALL behave as follows when imem_ack=1, EN=1 and redirect=0:
  - drive InstrF=imem_rdata, ValidF=1, PC_4F=PC+4 in the same cycle;
  - set PC<=PC+4 and stay in REQ, skipping HOLD.
  This allows a throughput of one instruction per cycle.
REQ-020 Without FETCH_BYPASS_EN, every instruction SHALL pass through HOLD, giving at least 2 cycles from request to consumption, and InstrF SHALL always be driven from a register.

Structure
REQ-021 A shared package SHALL hold the state-encoding typedef, RESET_PC=32'h0000_3000 and NOP=32'h0000_0000.
REQ-022 PC register and next-PC selection (PC+4 or redirect_pc, with alignment masking) SHALL sit in one sub-module, fetch_pc. The FSM and buffer SHALL stay in fetch_unit.

Verification
REQ-023 Release reset, ack after 1 wait cycle with rdata=32'h2408_0001, EN=1 -> imem_addr=32'h0000_3000; ValidF=1 with PC_4F=32'h0000_3004; next request at 32'h0000_3004.
REQ-024 HOLD with EN=0 for 5 cycles -> InstrF, PC_4F and ValidF stable; imem_req=0; then EN=1 -> next request at PC+4.
REQ-025 Redirect to 32'h0000_3102 in REQ with no ack; ack after 3 cycles -> data discarded, ValidF stays 0; next request at 32'h0000_3100.
REQ-026 Redirect and EN together in HOLD -> PC=redirect_pc; the held instruction is not re-presented; ValidF=0 the next cycle.
REQ-027 Reset pulsed low during KILL while ack arrives -> state IDLE, PC=32'h0000_3000, no ValidF pulse.
REQ-028 With FETCH_BYPASS_EN: ack every cycle and EN=1 -> ValidF=1 on consecutive cycles, PC_4F incrementing by 4 each cycle. Without the macro -> one instruction every 2 cycles.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// reset PC and the nop word presented when no instruction is live.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      KILL = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc.sv
// Fetch PC register with next-PC selection (sequential PC+4 or aligned
// redirect target). Arithmetic wraps modulo 2^32.
module fetch_pc
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        pc_en,
   input  logic        pc_sel_redir,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic [31:0] pc_next,
   output logic [31:0] pc_plus4
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Select the next PC; hold when no update is requested.
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      pc_d     = pc_q;
      if (pc_en) begin
         pc_d = pc_sel_redir ? align_word(redirect_pc) : pc_plus4;
      end
   end

   // PC register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc      = pc_q;
   assign pc_next = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches, buffers the returned
// instruction for the F/D register and handles redirects, including
// redirects that arrive while a request is still outstanding.
// Optional feature macro: FETCH_BYPASS_EN (forward imem_rdata straight to
// InstrF on ack when decode can accept it, one instruction per cycle).
module fetch_unit
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        EN,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrF,
   output logic [31:0] PC_4F,
   output logic        ValidF
);

   fetch_state_t state_q, state_d;
   logic [31:0]  buf_q, buf_d;
   logic [31:0]  addr_q, addr_d;
   logic         pc_en;
   logic         pc_sel_redir;
   logic         bypass_hit;
   logic [31:0]  pc;
   logic [31:0]  pc_next;
   logic [31:0]  pc_plus4;

   fetch_pc u_fetch_pc (
      .clk          (clk),
      .reset        (reset),
      .pc_en        (pc_en),
      .pc_sel_redir (pc_sel_redir),
      .redirect_pc  (redirect_pc),
      .pc           (pc),
      .pc_next      (pc_next),
      .pc_plus4     (pc_plus4)
   );

`ifdef FETCH_BYPASS_EN
   // Ack in REQ with decode ready: hand the word over without buffering.
   assign bypass_hit = reset && (state_q == REQ) && imem_ack && EN && !redirect;
`else
   assign bypass_hit = 1'b0;
`endif

   // Next state, buffer capture and PC update control.
   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      pc_en        = 1'b0;
      pc_sel_redir = 1'b0;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (redirect) begin
               pc_en        = 1'b1;
               pc_sel_redir = 1'b1;
               // Without ack the request is still in flight at the old address.
               state_d      = imem_ack ? REQ : KILL;
            end else if (imem_ack) begin
               if (bypass_hit) begin
                  pc_en = 1'b1;
               end else begin
                  buf_d   = imem_rdata;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_en        = 1'b1;
               pc_sel_redir = 1'b1;
               state_d      = REQ;
            end else if (EN) begin
               pc_en   = 1'b1;
               state_d = REQ;
            end
         end
         KILL: begin
            if (redirect) begin
               pc_en        = 1'b1;
               pc_sel_redir = 1'b1;
            end
            if (imem_ack) begin
               state_d = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
      // The address only moves when a new request starts, so it stays
      // stable for the whole lifetime of an outstanding request.
      addr_d = addr_q;
      if (state_d == REQ) begin
         addr_d = pc_next;
      end
   end

   // FSM, instruction buffer and request address registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         buf_q   <= NOP;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         addr_q  <= addr_d;
      end
   end

   // Output decode from the registered state.
   always_comb begin
      imem_req  = (state_q == REQ) || (state_q == KILL);
      imem_addr = addr_q;
      ValidF    = (state_q == HOLD) || bypass_hit;
      PC_4F     = pc_plus4;
      InstrF    = NOP;
      if (state_q == HOLD) begin
         InstrF = buf_q;
      end else if (bypass_hit) begin
         InstrF = imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by a
// randomized phase, all outputs compared every cycle against a
// transaction-level model of the fetch behaviour.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, EN, redirect, imem_ack;
   logic [31:0] redirect_pc, imem_rdata;
   logic        imem_req, ValidF;
   logic [31:0] imem_addr, InstrF, PC_4F;

   int total = 0;
   int bad   = 0;

`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .EN          (EN),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .InstrF      (InstrF),
      .PC_4F       (PC_4F),
      .ValidF      (ValidF)
   );

   // Model: fetch PC, whether the post-reset idle cycle passed, whether an
   // instruction is held for decode, address of the request in flight and
   // whether that in-flight response has been made useless by a redirect.
   logic [31:0] m_pc     = 32'h0000_3000;
   bit          m_started = 1'b0;
   bit          m_held    = 1'b0;
   logic [31:0] m_instr   = 32'h0;
   logic [31:0] m_addr    = 32'h0000_3000;
   bit          m_stale   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic set_in(input bit r, input bit e, input bit rd, input logic [31:0] rpc,
                         input bit a, input logic [31:0] rdat);
      @(negedge clk);
      reset       = r;
      EN          = e;
      redirect    = rd;
      redirect_pc = rpc;
      imem_ack    = a;
      imem_rdata  = rdat;
      #1;
   endtask

   // Compare every output against the model, then advance one clock.
   task automatic tick();
      bit          fetching, fwd;
      logic [31:0] exp_instr;
      fetching  = m_started && !m_held;
      fwd       = BYP && fetching && !m_stale && reset && imem_ack && EN && !redirect;
      exp_instr = m_held ? m_instr : (fwd ? imem_rdata : 32'h0);
      chk("m_req",   {31'b0, imem_req}, {31'b0, fetching});
      if (fetching) chk("m_addr", imem_addr, m_addr);
      chk("m_valid", {31'b0, ValidF}, {31'b0, (m_held || fwd)});
      chk("m_instr", InstrF, exp_instr);
      chk("m_pc4",   PC_4F, m_pc + 32'd4);
      @(posedge clk);
      if (!reset) begin
         m_pc = 32'h0000_3000; m_started = 0; m_held = 0;
         m_instr = 0; m_addr = 32'h0000_3000; m_stale = 0;
      end else if (!m_started) begin
         m_started = 1; m_addr = m_pc;
      end else if (m_held) begin
         if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC; m_held = 0; m_addr = m_pc;
         end else if (EN) begin
            m_pc = m_pc + 32'd4; m_held = 0; m_addr = m_pc;
         end
      end else if (m_stale) begin
         if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
         if (imem_ack) begin m_stale = 0; m_addr = m_pc; end
      end else if (imem_ack) begin
         if (redirect) begin
            m_pc = redirect_pc & 32'hFFFF_FFFC; m_addr = m_pc;
         end else if (BYP && EN) begin
            m_pc = m_pc + 32'd4; m_addr = m_pc;
         end else begin
            m_held = 1; m_instr = imem_rdata;
         end
      end else if (redirect) begin
         m_pc = redirect_pc & 32'hFFFF_FFFC; m_stale = 1;
      end
   endtask

   initial begin
      int vcnt;
      // Reset, with a stray ack arriving in the idle cycle afterwards.
      set_in(0, 0, 0, 0, 1, 32'h1234_5678); tick();
      set_in(0, 0, 0, 0, 0, 0);             tick();
      set_in(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
      chk("rst_req",   {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, ValidF}, 32'd0);
      chk("rst_instr", InstrF, 32'h0);
      chk("rst_pc4",   PC_4F, 32'h0000_3004);
      tick();

      // First fetch: one wait cycle then ack.
      set_in(1, 1, 0, 0, 0, 0);
      chk("first_addr", imem_addr, 32'h0000_3000);
      chk("first_req",  {31'b0, imem_req}, 32'd1);
      tick();
      set_in(1, !BYP, 0, 0, 1, 32'h2408_0001); tick();

      // Decode stalled for five cycles: outputs frozen.
      for (int i = 0; i < 5; i++) begin
         set_in(1, 0, 0, 32'h0000_5000, i[0], $urandom);
         chk("hold_valid", {31'b0, ValidF}, 32'd1);
         chk("hold_instr", InstrF, 32'h2408_0001);
         chk("hold_pc4",   PC_4F, 32'h0000_3004);
         chk("hold_req",   {31'b0, imem_req}, 32'd0);
         tick();
      end
      set_in(1, 1, 0, 0, 0, 0); tick();
      set_in(1, 0, 0, 0, 0, 0);
      chk("next_addr", imem_addr, 32'h0000_3004);
      tick();

      // Redirect with the request still in flight; late ack is discarded.
      set_in(1, 0, 1, 32'h0000_3102, 0, 0); tick();
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 0, 0, 0, 0);
         chk("kill_addr",  imem_addr, 32'h0000_3004);
         chk("kill_valid", {31'b0, ValidF}, 32'd0);
         tick();
      end
      set_in(1, 1, 0, 0, 1, 32'hBAD0_0BAD);
      chk("kill_ack_valid", {31'b0, ValidF}, 32'd0);
      tick();
      set_in(1, 0, 0, 0, 0, 0);
      chk("redir_addr", imem_addr, 32'h0000_3100);
      tick();

      // Redirect together with EN in HOLD: redirect wins.
      set_in(1, !BYP, 0, 0, 1, 32'h0000_0013); tick();
      set_in(1, 1, 1, 32'h0000_3200, 0, 0); tick();
      set_in(1, 0, 0, 0, 0, 0);
      chk("hredir_valid", {31'b0, ValidF}, 32'd0);
      chk("hredir_addr",  imem_addr, 32'h0000_3200);
      tick();

      // PC wrap at the top of the address space.
      set_in(1, 0, 1, 32'hFFFF_FFFF, 1, 32'h1111_1111); tick();
      set_in(1, !BYP, 0, 0, 1, 32'h2222_2222);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_pc4",  PC_4F, 32'h0);
      tick();
      set_in(1, 1, 0, 0, 0, 0); tick();
      set_in(1, 0, 0, 0, 0, 0);
      chk("wrap_next", imem_addr, 32'h0);
      tick();

      // Reset during KILL while the ack arrives.
      set_in(1, 0, 1, 32'h0000_3400, 0, 0); tick();
      set_in(0, 1, 0, 0, 1, 32'h3333_3333); tick();
      set_in(1, 1, 0, 0, 0, 0);
      chk("krst_req",   {31'b0, imem_req}, 32'd0);
      chk("krst_valid", {31'b0, ValidF}, 32'd0);
      chk("krst_pc4",   PC_4F, 32'h0000_3004);
      tick();
      set_in(1, 1, 0, 0, 0, 0);
      chk("krst_addr", imem_addr, 32'h0000_3000);
      tick();

      // Throughput with ack every cycle and decode always ready.
      vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         set_in(1, 1, 0, 0, 1, 32'hA000_0000 + i);
         if (ValidF) vcnt++;
         tick();
      end
      chk("throughput", vcnt, BYP ? 32'd8 : 32'd4);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC | $urandom_range(0, 3)) : $urandom;
         set_in($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, rpc, $urandom_range(0, 1) == 1, $urandom);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
